// File: rtl/neuron_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : neuron_pipelined
// Purpose  : Single neuron, dot product of N_INPUTS signed pairs plus bias,
//            with 1-cycle multiply pipeline and optional ReLU.
//            Define NEURON_SAT_EN to saturate the output, otherwise it wraps.
// Revision : 1.0 - initial release
// ============================================================================
module neuron_pipelined #(
    parameter int N_INPUTS   = 4,
    parameter int DATA_W     = 16,
    parameter int WEIGHT_W   = 16,
    parameter int BIAS_W     = 16,
    parameter int OUT_W      = 24,
    parameter int FRAC_SHIFT = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       act_sel,
    input  logic signed [BIAS_W-1:0]   bias,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [DATA_W-1:0]   in_data,
    input  logic signed [WEIGHT_W-1:0] in_weight,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [OUT_W-1:0]    out_data,
    output logic                       err_len
);

    localparam int ACC_W   = DATA_W + WEIGHT_W + $clog2(N_INPUTS) + 1;
    localparam int PROD_W  = DATA_W + WEIGHT_W;
    localparam int c_cnt_w = $clog2(N_INPUTS + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(N_INPUTS);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(N_INPUTS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACC   = 3'd1,
        DRAIN = 3'd2,
        BIAS  = 3'd3,
        ACT   = 3'd4,
        HOLD  = 3'd5
    } state_t;

    state_t                      r_state;
    logic signed [ACC_W-1:0]     r_acc;
    logic signed [PROD_W-1:0]    r_prod;
    logic                        r_prod_vld;
    logic [c_cnt_w-1:0]          r_cnt;
    logic                        r_act_sel;
    logic signed [BIAS_W-1:0]    r_bias;
    logic                        r_err;
    logic                        r_in_ready;
    logic                        r_out_valid;
    logic signed [OUT_W-1:0]     r_out_data;

    logic signed [ACC_W-1:0]     w_prod_ext;
    logic signed [ACC_W-1:0]     w_bias_ext;
    logic signed [ACC_W-1:0]     w_shifted;
    logic signed [ACC_W-1:0]     w_act;
    logic signed [OUT_W-1:0]     w_narrow;

    assign w_prod_ext = ACC_W'(r_prod);
    assign w_bias_ext = ACC_W'(r_bias);
    assign w_shifted  = r_acc >>> FRAC_SHIFT;
    assign w_act      = (r_act_sel && w_shifted[ACC_W-1]) ? '0 : w_shifted;

    generate
        if (OUT_W >= ACC_W) begin : g_wide
            assign w_narrow = OUT_W'(w_act);
        end else begin : g_narrow
`ifdef NEURON_SAT_EN
            localparam bit c_sat_en = 1'b1;
`else
            localparam bit c_sat_en = 1'b0;
`endif
            logic [ACC_W-OUT_W:0] w_top;
            logic                 w_in_range;
            logic [OUT_W-1:0]     w_clamp;

            // Value fits when all bits from the output sign bit upward agree.
            assign w_top      = w_act[ACC_W-1:OUT_W-1];
            assign w_in_range = (&w_top) || (~|w_top);
            assign w_clamp    = w_act[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                               : {1'b0, {(OUT_W-1){1'b1}}};
            assign w_narrow   = (c_sat_en && !w_in_range) ? w_clamp
                                                          : w_act[OUT_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_prod      <= '0;
            r_prod_vld  <= 1'b0;
            r_cnt       <= '0;
            r_act_sel   <= 1'b0;
            r_bias      <= '0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_act_sel  <= act_sel;
                        r_bias     <= bias;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_prod_vld <= 1'b0;
                        r_err      <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_state    <= ACC;
                    end
                end
                ACC: begin
                    if (r_prod_vld) begin
                        r_acc <= r_acc + w_prod_ext;
                    end
                    if (in_valid) begin
                        r_prod     <= in_data * in_weight;
                        r_prod_vld <= 1'b1;
                        if (r_cnt != c_cnt_max) begin
                            r_cnt <= r_cnt + c_cnt_w'(1);
                        end
                        if (in_last || (r_cnt == c_cnt_last)) begin
                            r_err      <= (r_cnt != c_cnt_last);
                            r_in_ready <= 1'b0;
                            r_state    <= DRAIN;
                        end
                    end else begin
                        r_prod_vld <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (r_prod_vld) begin
                        r_acc <= r_acc + w_prod_ext;
                    end
                    r_prod_vld <= 1'b0;
                    r_state    <= BIAS;
                end
                BIAS: begin
                    r_acc   <= r_acc + w_bias_ext;
                    r_state <= ACT;
                end
                ACT: begin
                    r_out_data  <= w_narrow;
                    r_out_valid <= 1'b1;
                    r_state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign err_len   = r_err;

endmodule
`default_nettype wire
